// File: rtl/rng_scheduler.sv
// Round-robin front end for one shared 8-bit LFSR: each grant decorrelates the
// generator by several steps, then bounds the draw to [0, max] by masked rejection.
module rng_scheduler #(
  parameter int         N_REQ     = 4,
  parameter logic [7:0] SEED      = 8'hA5,
  parameter int         STEPS     = 4,
  parameter int         MAX_TRIES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               reseed_i,
  input  logic [7:0]         seed_in_i,
  input  logic [N_REQ-1:0]   req_i,
  input  logic [8*N_REQ-1:0] max_val_i,
  output logic [N_REQ-1:0]   gnt_o,
  output logic               valid_o,
  output logic [7:0]         rand_val_o,
  output logic               busy_o
);

  localparam int IW = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, STEP, CHECK, DONE} state_e;

  state_e         state_q, state_d;
  logic [7:0]     lfsr_q;
  logic [IW-1:0]  ptr_q;
  logic [IW-1:0]  win_q;
  logic [7:0]     max_q;
  logic [3:0]     tries_q;
  logic [3:0]     stepCnt_q;
  logic           pend_q;
  logic [7:0]     pendSeed_q;
  logic [7:0]     rand_q;

  logic [7:0]     lfsrNext;
  logic [7:0]     smear1, smear2, mask;
  logic [7:0]     maskedVal;
  logic [7:0]     fallbackVal;
  logic           accept;
  logic           atLimit;
  logic           arbFound;
  logic [IW-1:0]  arbIdx;
  logic [IW-1:0]  cand;
  logic [7:0]     maxSel;

  // A zero state would lock the LFSR, so every load is forced non-zero.
  function automatic logic [7:0] nonZero(input logic [7:0] s);
    return (s == 8'h00) ? 8'h01 : s;
  endfunction

  assign lfsrNext = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  assign smear1      = max_q | (max_q >> 1);
  assign smear2      = smear1 | (smear1 >> 2);
  assign mask        = smear2 | (smear2 >> 4);
  assign maskedVal   = lfsr_q & mask;
  assign accept      = (maskedVal <= max_q);
  assign atLimit     = (tries_q == 4'(MAX_TRIES));
  assign fallbackVal = maskedVal - max_q - 8'd1;

  always_comb begin
    arbFound = 1'b0;
    arbIdx   = '0;
    cand     = '0;
    maxSel   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = IW'((int'(ptr_q) + i) % N_REQ);
      if (!arbFound && req_i[cand]) begin
        arbFound = 1'b1;
        arbIdx   = cand;
      end
    end
    for (int j = 0; j < N_REQ; j++) begin
      if (IW'(j) == arbIdx) maxSel = max_val_i[8*j +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // A reseed in IDLE takes the cycle, so a simultaneous request is arbitrated next cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (!reseed_i && arbFound) state_d = STEP;
      STEP:  if (stepCnt_q == 4'd0) state_d = CHECK;
      CHECK: state_d = (accept || atLimit) ? DONE : STEP;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_o      = '0;
    valid_o    = (state_q == DONE);
    busy_o     = (state_q != IDLE);
    rand_val_o = rand_q;
    if (state_q == DONE) gnt_o[win_q] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q     <= nonZero(SEED);
      ptr_q      <= IW'(N_REQ - 1);
      win_q      <= '0;
      max_q      <= '0;
      tries_q    <= '0;
      stepCnt_q  <= '0;
      pend_q     <= 1'b0;
      pendSeed_q <= '0;
      rand_q     <= '0;
    end else begin
      if (reseed_i && (state_q == STEP || state_q == CHECK)) begin
        pend_q     <= 1'b1;
        pendSeed_q <= seed_in_i;
      end
      unique case (state_q)
        IDLE: begin
          if (reseed_i) begin
            lfsr_q <= nonZero(seed_in_i);
          end else if (arbFound) begin
            win_q     <= arbIdx;
            ptr_q     <= arbIdx;
            max_q     <= maxSel;
            tries_q   <= '0;
            stepCnt_q <= 4'(STEPS - 1);
          end
        end
        STEP: begin
          lfsr_q <= lfsrNext;
          if (stepCnt_q != 4'd0) stepCnt_q <= stepCnt_q - 4'd1;
        end
        CHECK: begin
          if (accept) begin
            rand_q <= maskedVal;
          end else if (atLimit) begin
            rand_q <= fallbackVal;
          end else begin
            tries_q   <= tries_q + 4'd1;
            stepCnt_q <= 4'd0;
          end
        end
        DONE: begin
          tries_q <= '0;
          pend_q  <= 1'b0;
          if (reseed_i)    lfsr_q <= nonZero(seed_in_i);
          else if (pend_q) lfsr_q <= nonZero(pendSeed_q);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rng_scheduler.sv
// Directed bench for rng_scheduler: a reference LFSR/arbiter model fills a scoreboard
// at stimulus time, and each grant is popped and checked with immediate assertions.
module tb_rng_scheduler;

  localparam int N     = 4;
  localparam int STEPS = 4;
  localparam int MAXT  = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           reseed;
  logic [7:0]     seedIn;
  logic [N-1:0]   req;
  logic [8*N-1:0] maxVal;
  logic [N-1:0]   gnt;
  logic           valid;
  logic [7:0]     randVal;
  logic           busy;

  logic           fbReseed;
  logic [7:0]     fbSeed;
  logic [N-1:0]   fbReq;
  logic [8*N-1:0] fbMax;
  logic [N-1:0]   fbGnt;
  logic           fbValid;
  logic [7:0]     fbRand;
  logic           fbBusy;

  int total = 0;
  int bad   = 0;

  logic [7:0] mLfsr;
  int         mPtr;

  typedef struct {
    int         idx;
    logic [7:0] val;
    int         lat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  rng_scheduler #(.N_REQ(N), .SEED(8'hA5), .STEPS(STEPS), .MAX_TRIES(MAXT)) dut (
    .clk(clk), .rst(rst), .reseed_i(reseed), .seed_in_i(seedIn), .req_i(req),
    .max_val_i(maxVal), .gnt_o(gnt), .valid_o(valid), .rand_val_o(randVal), .busy_o(busy)
  );

  rng_scheduler #(.N_REQ(N), .SEED(8'hA5), .STEPS(STEPS), .MAX_TRIES(0)) dutFb (
    .clk(clk), .rst(rst), .reseed_i(fbReseed), .seed_in_i(fbSeed), .req_i(fbReq),
    .max_val_i(fbMax), .gnt_o(fbGnt), .valid_o(fbValid), .rand_val_o(fbRand), .busy_o(fbBusy)
  );

  function automatic logic [7:0] stepL(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  function automatic logic [7:0] maskFor(input logic [7:0] mx);
    logic [7:0] k;
    k = 8'h00;
    while (k < mx) k = {k[6:0], 1'b1};
    return k;
  endfunction

  function automatic logic [7:0] fixSeed(input logic [7:0] s);
    return (s == 8'h00) ? 8'h01 : s;
  endfunction

  task automatic modelDraw(input logic [7:0] mx, input int maxTries, input logic [7:0] lfIn,
                           output logic [7:0] lfOut, output logic [7:0] val, output int rej);
    logic [7:0] lf;
    logic [7:0] m;
    bit         fin;
    lf  = lfIn;
    rej = 0;
    fin = 0;
    for (int s = 0; s < STEPS; s++) lf = stepL(lf);
    while (!fin) begin
      m = lf & maskFor(mx);
      if (m <= mx) begin
        val = m;
        fin = 1;
      end else if (rej == maxTries) begin
        val = 8'(int'(m) - int'(mx) - 1);
        fin = 1;
      end else begin
        rej++;
        lf = stepL(lf);
      end
    end
    lfOut = lf;
  endtask

  function automatic int pickNext(input logic [N-1:0] r, input int last);
    for (int i = 1; i <= N; i++) begin
      if (r[(last + i) % N]) return (last + i) % N;
    end
    return 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reseedPulse(input logic [7:0] s);
    reseed = 1'b1;
    seedIn = s;
    @(posedge clk);
    @(negedge clk);
    reseed = 1'b0;
    mLfsr  = fixSeed(s);
  endtask

  task automatic waitGrant(input bit clearOnGrant);
    exp_t e;
    int   edges;
    bit   seen;
    edges = 0;
    seen  = 0;
    while (!seen && edges < 200) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      reseed = 1'b0;
      if (valid) seen = 1;
    end
    check("scoreboardNotEmpty", 32'(sb.size() != 0), 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check("grantSeen", 32'(seen), 32'd1);
    if (!seen) return;
    check("gnt", 32'(gnt), 32'(1 << e.idx));
    check("randVal", 32'(randVal), 32'(e.val));
    if (e.lat >= 0) check("latency", 32'(edges), 32'(e.lat));
    if (clearOnGrant) req[e.idx] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("validIsPulse", 32'(valid), 32'd0);
    check("randHeld", 32'(randVal), 32'(e.val));
  endtask

  task automatic singleDraw(input int idx, input logic [7:0] mx);
    exp_t       e;
    logic [7:0] nl;
    logic [7:0] v;
    int         rej;
    modelDraw(mx, MAXT, mLfsr, nl, v, rej);
    mLfsr = nl;
    mPtr  = idx;
    e.idx = idx;
    e.val = v;
    e.lat = STEPS + 2 + 2 * rej;
    sb.push_back(e);
    maxVal[8*idx +: 8] = mx;
    req[idx] = 1'b1;
    waitGrant(1'b1);
  endtask

  task automatic serveMulti(input logic [N-1:0] mask, input int n, input bit clearOnGrant);
    exp_t         e;
    logic [N-1:0] r;
    logic [7:0]   nl;
    logic [7:0]   v;
    int           rej;
    int           w;
    r = mask;
    for (int k = 0; k < n; k++) begin
      w = pickNext(r, mPtr);
      modelDraw(maxVal[8*w +: 8], MAXT, mLfsr, nl, v, rej);
      mLfsr = nl;
      mPtr  = w;
      e.idx = w;
      e.val = v;
      e.lat = -1;
      sb.push_back(e);
      if (clearOnGrant) r[w] = 1'b0;
    end
    req = mask;
    for (int k = 0; k < n; k++) waitGrant(clearOnGrant);
    req = '0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    exp_t       e;
    logic [7:0] nl;
    logic [7:0] v;
    int         rej;
    int         edges;
    int         validCount;

    rst      = 1'b1;
    reseed   = 1'b0;
    seedIn   = '0;
    req      = '0;
    maxVal   = '0;
    fbReseed = 1'b0;
    fbSeed   = '0;
    fbReq    = '0;
    fbMax    = '0;
    mLfsr    = 8'hA5;
    mPtr     = N - 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("resetBusy", 32'(busy), 32'd0);
    check("resetGnt", 32'(gnt), 32'd0);
    check("resetValid", 32'(valid), 32'd0);
    check("resetRand", 32'(randVal), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Two requesters held continuously alternate, starting with requester 1.
    maxVal = {8'h3F, 8'h07, 8'hFF, 8'h00};
    serveMulti(4'b1010, 3, 1'b0);

    // Single draws from seed 0x01 with full range, then a bounded draw with one rejection.
    reseedPulse(8'h01);
    singleDraw(0, 8'hFF);
    singleDraw(0, 8'hFF);
    reseedPulse(8'h01);
    singleDraw(1, 8'h10);

    // Reset mid-draw discards the draw and a pending reseed.
    maxVal[8*2 +: 8] = 8'hFF;
    req[2] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reseed = 1'b1;
    seedIn = 8'h3C;
    @(posedge clk);
    @(negedge clk);
    reseed = 1'b0;
    check("busyBeforeReset", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("rstBusy", 32'(busy), 32'd0);
    check("rstGnt", 32'(gnt), 32'd0);
    check("rstValid", 32'(valid), 32'd0);
    @(negedge clk);
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    mLfsr = 8'hA5;
    mPtr  = N - 1;
    validCount = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (valid) validCount++;
    end
    check("noGrantAfterReset", 32'(validCount), 32'd0);

    // All four requesters: grants rotate 0,1,2,3 from the reset pointer.
    maxVal = {8'h80, 8'h10, 8'h05, 8'hFF};
    serveMulti(4'b1111, 4, 1'b1);

    // Zero seed is corrected to 0x01.
    reseedPulse(8'h00);
    singleDraw(2, 8'hFF);

    // Reseed together with a request: reseed wins, arbitration one cycle later.
    mLfsr = 8'h5A;
    modelDraw(8'h80, MAXT, mLfsr, nl, v, rej);
    mLfsr = nl;
    mPtr  = 3;
    e.idx = 3;
    e.val = v;
    e.lat = STEPS + 3 + 2 * rej;
    sb.push_back(e);
    maxVal[8*3 +: 8] = 8'h80;
    reseed = 1'b1;
    seedIn = 8'h5A;
    req[3] = 1'b1;
    waitGrant(1'b1);

    // Reseed during STEP is deferred; dropping req after latch does not cancel.
    modelDraw(8'hFF, MAXT, mLfsr, nl, v, rej);
    e.idx = 0;
    e.val = v;
    e.lat = -1;
    sb.push_back(e);
    mPtr = 0;
    maxVal[8*0 +: 8] = 8'hFF;
    req[0] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("busyDuringStep", 32'(busy), 32'd1);
    reseed = 1'b1;
    seedIn = 8'h01;
    req[0] = 1'b0;
    waitGrant(1'b1);
    mLfsr = 8'h01;
    singleDraw(0, 8'hFF);

    // Fallback instance allows no rejections.
    fbReseed = 1'b1;
    fbSeed   = 8'h01;
    @(posedge clk);
    @(negedge clk);
    fbReseed = 1'b0;
    modelDraw(8'h10, 0, 8'h01, nl, v, rej);
    fbMax[7:0] = 8'h10;
    fbReq[0]   = 1'b1;
    edges = 0;
    while (!fbValid && edges < 200) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    fbReq = '0;
    check("fbValid", 32'(fbValid), 32'd1);
    check("fbRand", 32'(fbRand), 32'(v));
    check("fbGnt", 32'(fbGnt), 32'd1);
    check("fbLatency", 32'(edges), 32'(STEPS + 2 + 2 * rej));
    @(negedge clk);

    // Randomised draws against the model, including narrow ranges.
    for (int k = 0; k < 8; k++) begin
      singleDraw(int'($urandom_range(0, N - 1)),
                 8'($urandom_range(0, 255) >> $urandom_range(0, 7)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rng_scheduler.md
# rng_scheduler

Shares one 8-bit maximal-length LFSR among `N_REQ` game-logic requesters, such as hunger, mood and mini-game events. Requesters are served round-robin. For each grant the block advances the LFSR a fixed number of steps to decorrelate successive draws. It then returns a value bounded to a per-request range `[0, max]` using masked rejection sampling with a deterministic fallback. Seed control (power-on seed, runtime reseed, zero-lock protection) is handled here, so consumers never touch the LFSR directly.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `SEED`, default 8'hA5: LFSR value loaded at reset.
- `STEPS`, default 4: LFSR advances per draw, 1..15.
- `MAX_TRIES`, default 4: rejections allowed before fallback, 0..15.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `reseed` in 1: single-cycle pulse that loads `seed_in`.
- `seed_in` in 8: new LFSR seed.
- `req` in N_REQ: level request per requester, held until its `gnt`.
- `max_val` in 8*N_REQ: inclusive upper bound per requester; slice i = `[8*i+7:8*i]`.
- `gnt` out N_REQ: one-hot, one-cycle pulse; result for that requester.
- `valid` out 1: one-cycle pulse coincident with `gnt`.
- `rand_val` out 8: result, held until the next `valid`.
- `busy` out 1: high whenever state is not IDLE.

## Operation
- **LFSR**
  - Next = `{s[6:0], s[7]^s[5]^s[4]^s[3]}`.
  - Advances only in STEP.
  - Any load of 8'h00 (from `SEED` or `seed_in`) is replaced by 8'h01.
- **Reset values**
  - LFSR = `SEED` (zero-corrected).
  - State IDLE; `gnt` = 0; `valid` = 0; `rand_val` = 0; `busy` = 0.
  - Round-robin last-grant pointer = N_REQ-1, so requester 0 has first priority.
  - Pending-reseed flag cleared.
- **Arbitration**
  - In IDLE with `req` != 0, select the first asserted index searching upward from (last+1) mod N_REQ.
  - Latch the winner index and its `max_val` slice.
  - Update the pointer and go to STEP.
- **Mask**
  - Smallest 2^k-1 that is ≥ latched max: max=0 → 0x00, max=5 → 0x07, max=0x10 → 0x1F, max≥0x80 → 0xFF.
- **FSM**
  - IDLE: wait for `req`.
  - STEP: advance the LFSR once per cycle for `STEPS` cycles, or 1 cycle when re-entered after a rejection.
  - CHECK: compute m = LFSR & mask.
    - If m ≤ max: accept, result = m.
    - Else if tries == MAX_TRIES: fallback, result = m − (max+1). This is always ≤ max, since m < 2·(max+1).
    - Else: tries++ and return to STEP for 1 cycle.
  - DONE: register `rand_val`, pulse `gnt[winner]` and `valid`, clear tries, return to IDLE.
- **Reseed**
  - A pulse in IDLE loads the LFSR next cycle.
  - A pulse while busy sets a pending flag holding `seed_in`. The load is applied on the DONE→IDLE transition, after the current draw finishes.
  - A later pulse overwrites the pending value.
  - If `reseed` and `req` arrive together in IDLE, the reseed applies first and arbitration waits one cycle.
- **Request rules**
  - Dropping `req` after it is latched does not cancel the draw.
  - Requests arriving while busy wait; none is lost while held.

## Timing
- `req` sampled in IDLE at cycle t gives `gnt`/`valid` at t+STEPS+2 with no rejections.
- Each rejection adds 2 cycles (STEP + CHECK).
- Worst case: t + STEPS + 2 + 2·MAX_TRIES.
- The earliest next arbitration is the cycle after DONE, so back-to-back grants are separated by at least STEPS+3 cycles.
- `rand_val` changes only in the cycle `valid` is high.
- Asserting `rst` mid-draw aborts the draw: no `gnt` is issued, the pending reseed is discarded, and the LFSR returns to `SEED`.

## Test plan
- **Seed and single draw.** STEPS=4, `reseed` with 0x01, then `req`=0001 with max=0xFF. LFSR goes 02,04,08,11; `rand_val`=0x11 at t+6. A second request returns 0x1C (23,47,8E,1C).
- **Rejection.** Seed 0x01, max=0x10. At CHECK, 0x11 is rejected (17>16). After one more step, 0x23&0x1F=3 is accepted: `rand_val`=3 at t+8.
- **Fallback.** MAX_TRIES=0, seed 0x01, max=0x10. `rand_val`=0 (17−17) at t+6.
- **Round-robin.** `req`=1010 held from reset. Grants come as 0010, 1000, 0010…; with `req`=1111, grants rotate 0,1,2,3.
- **Zero seed and deferred reseed.**
  - `reseed` with 0x00 loads LFSR 0x01.
  - A `reseed` with 0x01 during STEP does not change the current result; the next draw starts from 0x01.
- **Reset mid-draw.** Assert `rst` during STEP. `gnt`, `valid` and `busy` drop immediately, and no grant is issued after release.
